// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures period and high time of an external PWM input
// and converts them to a duty code in tenths (0..10), rounded to nearest.
// A static input is reported through the timeout flag. A rise that arrives
// while a division is still running is dropped and flagged as an overrun.
module pwm_duty_decoder #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [3:0]       duty_code,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             duty_valid,
  output logic             timeout,
  output logic             overrun
);

  localparam int               NUM_W     = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

  state_t state, state_next;

  logic             sync_a, sync_b, prev;
  logic             rise;
  logic [CNT_W-1:0] per_cnt, hi_cnt;
  logic [CNT_W-1:0] snap_period, snap_high;
  logic             timeout_hit;

  logic             load_div, div_iter, div_last, report_timeout, drop;

  logic [NUM_W-1:0] rem, dsh, rem_next, num_init;
  logic [3:0]       quot, quot_final, quot_clamped;
  logic [2:0]       step;
  logic             q_bit;
  logic [CNT_W-1:0] div_period, div_high;

  // Two-flop synchronizer for the pad input plus the previous-value flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync_a <= pwm_in;
      sync_b <= sync_a;
      prev   <= sync_b;
    end
  end

  assign rise = sync_b & ~prev;

  // Period and high-time counters restart on every rise (the rise cycle itself is high) and saturate.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= '0;
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_W'(1);
      if (sync_b && (hi_cnt != CNT_MAX)) hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  // The period snapshot saturates instead of wrapping, which also keeps the divisor non-zero.
  assign snap_period = (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CNT_W'(1);
  assign snap_high   = hi_cnt;
  assign timeout_hit = (per_cnt >= TIMEOUT_C);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a rise always beats a simultaneous timeout in MEASURE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = MEASURE;
      MEASURE: begin
        if (rise)             state_next = DIVIDE;
        else if (timeout_hit) state_next = IDLE;
      end
      DIVIDE:  if (step == 3'd4) state_next = MEASURE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: steps 0..3 of DIVIDE produce quotient bits, step 4 is the completion cycle.
  always_comb begin
    load_div       = 1'b0;
    div_iter       = 1'b0;
    div_last       = 1'b0;
    report_timeout = 1'b0;
    drop           = 1'b0;
    case (state)
      MEASURE: begin
        load_div       = rise;
        report_timeout = ~rise & timeout_hit;
      end
      DIVIDE: begin
        div_iter = ~step[2];
        div_last = (step == 3'd3);
        drop     = rise;
      end
      default: ;
    endcase
  end

  // Numerator 10*high + period/2 gives round-half-up; built from shifts to stay width-exact.
  assign num_init = (NUM_W'(snap_high) << 3) + (NUM_W'(snap_high) << 1)
                  + NUM_W'(snap_period >> 1);

  assign q_bit        = (rem >= dsh);
  assign rem_next     = q_bit ? (rem - dsh) : rem;
  assign quot_final   = {quot[2:0], q_bit};
  assign quot_clamped = (quot_final > 4'd10) ? 4'd10 : quot_final;

  // Restoring divider: loads on a measured rise, then one quotient bit per cycle, MSB first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem        <= '0;
      dsh        <= '0;
      quot       <= '0;
      step       <= '0;
      div_period <= '0;
      div_high   <= '0;
    end else if (load_div) begin
      rem        <= num_init;
      dsh        <= NUM_W'(snap_period) << 3;
      quot       <= '0;
      step       <= '0;
      div_period <= snap_period;
      div_high   <= snap_high;
    end else if (div_iter) begin
      rem  <= rem_next;
      dsh  <= dsh >> 1;
      quot <= quot_final;
      step <= step + 3'd1;
    end
  end

  // Result registers: hold between reports; duty_valid and overrun are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_code  <= '0;
      period_out <= '0;
      high_out   <= '0;
      duty_valid <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      duty_valid <= 1'b0;
      overrun    <= drop;
      if (div_last) begin
        duty_code  <= quot_clamped;
        period_out <= div_period;
        high_out   <= div_high;
        timeout    <= 1'b0;
        duty_valid <= 1'b1;
      end else if (report_timeout) begin
        duty_code  <= sync_b ? 4'd10 : 4'd0;
        period_out <= '0;
        high_out   <= '0;
        timeout    <= 1'b1;
        duty_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Testbench for pwm_duty_decoder: table-driven vectors, hand-written corner
// sequences and randomized waveforms, all scored against a waveform-level
// reference model that works on whole periods rather than on DUT state.
module tb_pwm_duty_decoder;

  localparam int CNT_W = 16;
  localparam int TO    = 100;

  logic             clk;
  logic             rst;
  logic             pwm_in;
  logic [3:0]       duty_code;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             duty_valid;
  logic             timeout;
  logic             overrun;

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .duty_code (duty_code),
    .period_out(period_out),
    .high_out  (high_out),
    .duty_valid(duty_valid),
    .timeout   (timeout),
    .overrun   (overrun)
  );

  typedef struct {
    int duty;
    int period;
    int high;
    int tmo;
  } rep_t;

  typedef struct {
    int period;
    int high;
    int expDuty;
  } vec_t;

  int   vectors     = 0;
  int   miscompares = 0;

  rep_t expQ[$];
  int   mCyc        = 0;
  bit   mIdle       = 1'b1;
  bit   mPrev       = 1'b0;
  int   mLastRise   = 0;
  int   mHighs      = 0;
  int   mBusyUntil  = -1;
  int   expOverrun  = 0;

  int   validCount  = 0;
  int   overrunSeen = 0;
  int   lastDuty    = 0;
  int   lastPeriod  = 0;
  int   lastHigh    = 0;
  int   lastTmo     = 0;

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: one call per input sample. Reports are derived from the
  // spacing of rising edges, the count of high samples between them, and a
  // five-sample busy window after each measured rise.
  task automatic modelStep(input bit b);
    bit rise;
    int p, h, d;
    rise = b && !mPrev;
    if (rise) begin
      if (!mIdle) begin
        if (mCyc <= mBusyUntil) begin
          expOverrun++;
        end else begin
          p = mCyc - mLastRise;
          h = mHighs;
          d = (20 * h + p) / (2 * p);
          if (d > 10) d = 10;
          expQ.push_back('{d, p, h, 0});
          mBusyUntil = mCyc + 5;
        end
      end
      mIdle     = 1'b0;
      mLastRise = mCyc;
      mHighs    = 0;
    end else if (!mIdle && mCyc > mBusyUntil && (mCyc - mLastRise) > TO) begin
      expQ.push_back('{b ? 10 : 0, 0, 0, 1});
      mIdle = 1'b1;
    end
    if (b) mHighs++;
    mPrev = b;
    mCyc++;
  endtask

  task automatic modelReset();
    expQ.delete();
    mIdle      = 1'b1;
    mPrev      = 1'b0;
    mHighs     = 0;
    mBusyUntil = mCyc - 1;
  endtask

  task automatic driveBit(input bit b);
    pwm_in = b;
    modelStep(b);
    @(posedge clk);
    #1;
  endtask

  task automatic driveLevel(input bit b, input int n);
    repeat (n) driveBit(b);
  endtask

  task automatic applyStimulus(input int p, input int h, input int reps);
    repeat (reps) begin
      for (int i = 0; i < p; i++) driveBit(i < h);
    end
  endtask

  // Monitor: every report is popped from the model queue and compared field by field.
  always @(negedge clk) begin
    if (!rst) begin
      if (overrun) overrunSeen++;
      if (duty_valid) begin
        validCount++;
        lastDuty   = int'(duty_code);
        lastPeriod = int'(period_out);
        lastHigh   = int'(high_out);
        lastTmo    = int'(timeout);
        if (expQ.size() == 0) begin
          checkOutput("spurious_valid", int'(duty_valid), 0);
        end else begin
          rep_t e;
          e = expQ.pop_front();
          checkOutput("sb_duty",    lastDuty,   e.duty);
          checkOutput("sb_period",  lastPeriod, e.period);
          checkOutput("sb_high",    lastHigh,   e.high);
          checkOutput("sb_timeout", lastTmo,    e.tmo);
        end
      end
    end
  end

  // Main sequence.
  initial begin
    vec_t table_v[12];
    int   p, h, kind, vc0, ov0, eov0;

    table_v[0]  = '{10, 5, 5};
    table_v[1]  = '{20, 7, 4};
    table_v[2]  = '{20, 1, 1};
    table_v[3]  = '{12, 1, 1};
    table_v[4]  = '{10, 1, 1};
    table_v[5]  = '{10, 9, 9};
    table_v[6]  = '{20, 19, 10};
    table_v[7]  = '{10, 4, 4};
    table_v[8]  = '{20, 10, 5};
    table_v[9]  = '{20, 3, 2};
    table_v[10] = '{20, 13, 7};
    table_v[11] = '{10, 6, 6};

    pwm_in = 1'b0;
    rst    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_duty",     int'(duty_code),  0);
    checkOutput("reset_period",   int'(period_out), 0);
    checkOutput("reset_high",     int'(high_out),   0);
    checkOutput("reset_valid",    int'(duty_valid), 0);
    checkOutput("reset_timeout",  int'(timeout),    0);
    checkOutput("reset_overrun",  int'(overrun),    0);
    rst = 1'b0;
    modelReset();

    // Steady 50% train: the first rise is silent, every later one reports.
    vc0 = validCount;
    ov0 = overrunSeen;
    applyStimulus(10, 5, 20);
    checkOutput("steady_count",   validCount - vc0,  19);
    checkOutput("steady_overrun", overrunSeen - ov0, 0);
    checkOutput("steady_duty",    lastDuty,   5);
    checkOutput("steady_period",  lastPeriod, 10);
    checkOutput("steady_high",    lastHigh,   5);
    checkOutput("steady_timeout", lastTmo,    0);

    // Table of fixed waveforms including rounding and single-cycle pulses.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(table_v[i].period, table_v[i].high, 4);
      checkOutput("tbl_duty",   lastDuty,   table_v[i].expDuty);
      checkOutput("tbl_period", lastPeriod, table_v[i].period);
      checkOutput("tbl_high",   lastHigh,   table_v[i].high);
    end

    // High-time sweep over two periods.
    for (int hh = 1; hh < 10; hh++) begin
      applyStimulus(10, hh, 3);
      applyStimulus(20, hh, 3);
    end

    // Static low, static high, then resume.
    vc0 = validCount;
    driveLevel(1'b0, TO + 10);
    checkOutput("tmo_low_count",  validCount - vc0, 1);
    checkOutput("tmo_low_flag",   lastTmo,    1);
    checkOutput("tmo_low_duty",   lastDuty,   0);
    checkOutput("tmo_low_period", lastPeriod, 0);
    checkOutput("tmo_low_high",   lastHigh,   0);
    vc0 = validCount;
    driveLevel(1'b1, TO + 10);
    checkOutput("tmo_high_count", validCount - vc0, 1);
    checkOutput("tmo_high_flag",  lastTmo,    1);
    checkOutput("tmo_high_duty",  lastDuty,   10);
    applyStimulus(10, 3, 4);
    checkOutput("resume_duty",    lastDuty,   3);
    checkOutput("resume_timeout", lastTmo,    0);
    checkOutput("resume_period",  lastPeriod, 10);

    // Period shorter than the divider busy window.
    ov0  = overrunSeen;
    eov0 = expOverrun;
    applyStimulus(4, 2, 10);
    driveLevel(1'b0, 12);
    checkOutput("ovr_count",  overrunSeen - ov0, expOverrun - eov0);
    checkOutput("ovr_period", lastPeriod, 4);
    checkOutput("ovr_duty",   lastDuty,   5);

    // Reset two cycles after a rise aborts the division in progress.
    applyStimulus(10, 5, 3);
    driveLevel(1'b1, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    checkOutput("midrst_duty",    int'(duty_code),  0);
    checkOutput("midrst_period",  int'(period_out), 0);
    checkOutput("midrst_high",    int'(high_out),   0);
    checkOutput("midrst_valid",   int'(duty_valid), 0);
    checkOutput("midrst_timeout", int'(timeout),    0);
    vc0 = validCount;
    applyStimulus(10, 5, 4);
    checkOutput("midrst_count",  validCount - vc0, 3);
    checkOutput("midrst_after",  lastDuty, 5);

    // Randomized mix of normal trains, short periods and static holds.
    for (int s = 0; s < 30; s++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        p = $urandom_range(6, 30);
        h = $urandom_range(1, p - 1);
        applyStimulus(p, h, $urandom_range(1, 4));
      end else if (kind < 8) begin
        p = $urandom_range(2, 5);
        h = $urandom_range(1, p - 1);
        applyStimulus(p, h, $urandom_range(2, 6));
      end else begin
        driveLevel(1'($urandom_range(0, 1)), TO + $urandom_range(2, 20));
      end
    end

    driveLevel(1'b0, 20);
    checkOutput("pending_reports", expQ.size(), 0);
    checkOutput("overrun_total",   overrunSeen, expOverrun);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
